// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for the bit-serial adder: operands and carry-in
// from the requester, busy/done status and registered result back.
interface serial_adder_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder slice (two half adders plus an OR)
// with a registered carry, consuming one operand bit pair per cycle, LSB first.
module serial_adder #(
    parameter int N = 8
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  ra;
    logic [N-1:0]  rb;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sum_q;
    logic          cout_q;

    logic          half_s;
    logic          half_c;
    logic          slice_s;
    logic          slice_c;
    logic          last_bit;
    logic [N-1:0]  sum_shifted;

    // Full-adder slice built from two half adders; the result bit enters at the MSB.
    always_comb begin
        half_s      = ra[0] ^ rb[0];
        half_c      = ra[0] & rb[0];
        slice_s     = half_s ^ carry;
        slice_c     = half_c | (half_s & carry);
        last_bit    = (cnt == CW'(N - 1));
        sum_shifted = sum_q >> 1;
        sum_shifted[N-1] = slice_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra     <= '0;
            rb     <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ra     <= bus.a;
                        rb     <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q <= sum_shifted;
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    carry <= slice_c;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        cout_q <= slice_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random
// operands, checked against a plain a+b+cin reference.
module tb_serial_adder;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_adder_if #(.N(N)) bus ();

    serial_adder #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
    task automatic apply_stimulus(input logic [N-1:0] ta, input logic [N-1:0] tb,
                                  input logic tc, input int glitch_at, input string tag);
        logic [N:0] expected;
        int         busy_cnt;
        int         wait_cnt;
        expected  = {1'b0, ta} + {1'b0, tb} + {{N{1'b0}}, tc};
        bus.a     = ta;
        bus.b     = tb;
        bus.cin   = tc;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt  = 0;
        wait_cnt  = 0;
        while (bus.done !== 1'b1 && wait_cnt < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (wait_cnt == glitch_at) begin
                bus.start = 1'b1;
                bus.a     = '1;
                bus.b     = '1;
                bus.cin   = ~tc;
            end else if (wait_cnt == glitch_at + 1) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            wait_cnt++;
        end
        bus.start = 1'b0;
        check_output({tag, ".busy_cycles"}, busy_cnt, N);
        check_output({tag, ".done"}, 32'(bus.done), 32'd1);
        check_output({tag, ".busy_in_done"}, 32'(bus.busy), 32'd0);
        check_output({tag, ".sum"}, 32'(bus.sum), 32'(expected[N-1:0]));
        check_output({tag, ".cout"}, 32'(bus.cout), 32'(expected[N]));
        @(negedge clk);
        check_output({tag, ".done_single"}, 32'(bus.done), 32'd0);
        check_output({tag, ".busy_after"}, 32'(bus.busy), 32'd0);
        check_output({tag, ".sum_held"}, 32'(bus.sum), 32'(expected[N-1:0]));
    endtask

    initial begin
        int done_seen;
        total     = 0;
        bad       = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        #2;
        check_output("reset.busy", 32'(bus.busy), 32'd0);
        check_output("reset.done", 32'(bus.done), 32'd0);
        check_output("reset.sum", 32'(bus.sum), 32'd0);
        check_output("reset.cout", 32'(bus.cout), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("idle.busy", 32'(bus.busy), 32'd0);
            check_output("idle.done", 32'(bus.done), 32'd0);
        end

        $display("[TB] directed adds");
        apply_stimulus(8'h5A, 8'h3C, 1'b0, -1, "basic");
        apply_stimulus(8'hFF, 8'h01, 1'b0, -1, "ripple");
        apply_stimulus(8'hFF, 8'hFF, 1'b1, -1, "maxcin");
        apply_stimulus(8'h10, 8'h20, 1'b0, 3, "ignored");
        apply_stimulus(8'h01, 8'h02, 1'b0, -1, "back2back");

        $display("[TB] reset mid-operation");
        bus.a     = 8'h5A;
        bus.b     = 8'h3C;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_output("midrst.busy_before", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_output("midrst.busy", 32'(bus.busy), 32'd0);
        check_output("midrst.done", 32'(bus.done), 32'd0);
        check_output("midrst.sum", 32'(bus.sum), 32'd0);
        check_output("midrst.cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        check_output("midrst.no_done", done_seen, 0);
        apply_stimulus(8'h01, 8'h02, 1'b0, -1, "after_rst");

        $display("[TB] random adds");
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(N'($urandom), N'($urandom), 1'($urandom), -1, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
